mips_fetch_unit: RTL and testbench
==================================

Name: mips_fetch_unit

Overview:
- Instruction-fetch initiator for the MIPS core; it is the requesting end of the combinational instruction-memory interface (instr_address out, instr_readdata in).
- Holds the PC from reset vector 0xBFC00000 and registers each fetched word into a one-entry fetch/decode register.
- Applies branch/jump redirects with MIPS branch-delay-slot semantics.
- Detects the halt condition, a fetch from address 0x00000000 after "jr r0", and stops fetching.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, fetch address that terminates execution.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr_address  output  32  fetch address; always equals the PC register.
- instr_readdata  input  32  instruction word, valid combinationally in the same cycle as instr_address.
- stall  input  1  freezes PC, IR and counters for this cycle.
- redirect_valid  input  1  decode reports a taken branch/jump for the instruction currently in IR.
- redirect_target  input  32  target PC of the taken branch/jump.
- instr  output  32  registered instruction word (IR) for decode.
- instr_pc  output  32  address IR was fetched from.
- instr_valid  output  1  IR holds a real fetched instruction.
- active  output  1  high while the CPU is running; low after halt.
- addr_error  output  1  sticky flag: a misaligned redirect target was presented.
- fetch_count  output  32  number of words fetched since reset.

Behaviour:
- Reset (rst_n low, asynchronous): pc=RESET_VECTOR, instr=0, instr_pc=0, instr_valid=0, active=1, addr_error=0, fetch_count=0.
- Advance cycle = rising edge with rst_n high, stall=0 and active=1. On an advance cycle:
  - instr <= instr_readdata
  - instr_pc <= pc
  - instr_valid <= 1
  - fetch_count <= fetch_count+1
  - pc <= next_pc
- next_pc:
  - If redirect_valid && instr_valid: next_pc = redirect_target.
  - Otherwise: next_pc = pc+4, with 32-bit wrap (0xFFFFFFFC+4 = 0).
- Delay slot: a redirect is presented while the branch sits in IR. By then the PC already points at branch_pc+4, so the delay-slot word is fetched on the same edge and the target is fetched next. The delay slot is never squashed.
- redirect_valid while instr_valid=0 is ignored.
- Misaligned redirect: a redirect with redirect_target[1:0]!=0 on an advance cycle sets addr_error (sticky until reset). The PC is still loaded with {redirect_target[31:2],2'b00}.
- Stall: with stall=1 nothing changes. A redirect must be held by decode until the first non-stalled edge, and is sampled only on that edge.
- Halt, when pc==HALT_ADDR on an advance cycle:
  - The word is captured as usual; memory returns a nop at 0.
  - active <= 0, and pc holds at HALT_ADDR.
  - On all subsequent edges instr_valid <= 0, and pc, instr and fetch_count hold.
  - A redirect on the halt edge is ignored.
- Halted state persists until reset. instr_address stays 0 while halted.
- Reset mid-operation: all state returns to reset values immediately, regardless of stall/redirect. Fetch resumes from RESET_VECTOR on the first edge after rst_n rises.
- Latency: a word presented in cycle N appears on instr in cycle N+1. Throughput is 1 word/cycle when not stalled.
- No combinational path from instr_readdata to any output.

Decomposition:
- Shared package mips_pkg:
  - RESET_VECTOR / HALT_ADDR constants
  - opcode/funct localparams (JR=6'b001000, ADDIU=6'b001001, LBU=6'b100100, SW=6'b101011)
  - a fetch_state typedef {RUN, HALTED}
- One sub-module is natural: mips_pc_next, the combinational next-PC/alignment mux producing next_pc and misaligned.
- State machine: RUN -> HALTED on an advance cycle with pc==HALT_ADDR; HALTED -> RUN only via reset.

Test Plan:
1. Sequential fetch: release reset, no stall, memory returns word = address. After 3 edges: instr_address=0xBFC0000C, instr=0xBFC00008, instr_pc=0xBFC00008, fetch_count=3, instr_valid=1.
2. Branch with delay slot: redirect_valid=1, redirect_target=0xBFC00040 while instr_pc=0xBFC00008. Next instr_pc sequence is 0xBFC0000C (delay slot), then 0xBFC00040.
3. Stall: assert stall for 4 cycles mid-stream. instr, instr_pc, pc and fetch_count are unchanged throughout. The redirect is held and takes effect on the first non-stalled edge.
4. Halt: program "jr r0; nop" at 0xBFC00028/0x2C, redirect to 0. The fetch at 0 yields instr=0 and instr_pc=0, then active=0, instr_valid=0 one edge later. fetch_count is frozen and the PC stays 0 for 20 further cycles.
5. Misaligned redirect: redirect_target=0xBFC00042. addr_error=1 and stays 1, and the next instr_pc is 0xBFC00040.
6. Async reset mid-run: drop rst_n between edges. All outputs return to reset values before the next edge, and the first fetch after release is from 0xBFC00000.

Source files
------------

// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared constants and types for the MIPS front end.
//   RESET_VECTOR / HALT_ADDR : fetch-address constants (boot ROM entry, halt)
//   OP_* / FN_*              : opcode and funct field encodings used by decode
//   fetch_state_t            : run/halt state of the fetch unit
// ----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] HALT_ADDR    = 32'h0000_0000;

    // R-type funct code for "jr"
    localparam logic [5:0] FN_JR    = 6'b001000;
    // I-type opcodes
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/mips_pc_next.sv
// ----------------------------------------------------------------------------
// mips_pc_next
// Combinational next-PC selection with redirect alignment.
//   pc_i              : current PC
//   instr_valid_i     : IR holds a real instruction (redirects only count then)
//   redirect_valid_i  : decode reports a taken branch/jump for IR
//   redirect_target_i : branch/jump target
//   next_pc_o         : PC to load on an advance cycle
//   misaligned_o      : a redirect is taken and its target is not word aligned
// ----------------------------------------------------------------------------
module mips_pc_next (
    input  logic [31:0] pc_i,
    input  logic        instr_valid_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_target_i,
    output logic [31:0] next_pc_o,
    output logic        misaligned_o
);

    logic takeRedirect;

    // A redirect with no valid instruction in IR cannot belong to a real
    // branch, so it is ignored.
    assign takeRedirect = redirect_valid_i && instr_valid_i;

    // Misaligned targets are still followed, but forced onto a word boundary
    // so the PC never carries low-order bits. Sequential fetch wraps at 2^32.
    always_comb begin
        next_pc_o    = pc_i + 32'd4;
        misaligned_o = 1'b0;
        if (takeRedirect) begin
            next_pc_o    = {redirect_target_i[31:2], 2'b00};
            misaligned_o = (redirect_target_i[1:0] != 2'b00);
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// ----------------------------------------------------------------------------
// mips_fetch_unit
// Instruction-fetch front end: PC register, one-entry fetch/decode register,
// branch-delay-slot redirects and halt detection (fetch from HALT_ADDR).
//   clk, rst_n      : clock, asynchronous active-low reset
//   instr_address   : fetch address (the PC register)
//   instr_readdata  : instruction word for instr_address, same cycle
//   stall           : freeze all state for this cycle
//   redirect_valid  : taken branch/jump for the instruction in IR
//   redirect_target : its target address
//   instr, instr_pc : IR contents and the address they came from
//   instr_valid     : IR holds a real fetched instruction
//   active          : CPU running (low once halted)
//   addr_error      : sticky, a misaligned redirect target was taken
//   fetch_count     : words fetched since reset
// ----------------------------------------------------------------------------
module mips_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = mips_pkg::RESET_VECTOR,
    parameter logic [31:0] HALT_ADDR    = mips_pkg::HALT_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        active,
    output logic        addr_error,
    output logic [31:0] fetch_count
);

    import mips_pkg::*;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         instr_valid_q, instr_valid_d;
    logic         addr_error_q, addr_error_d;
    logic [31:0]  fetch_count_q, fetch_count_d;

    logic [31:0]  nextPc;
    logic         misaligned;
    logic         advance;
    logic         haltNow;

    mips_pc_next u_pc_next (
        .pc_i              (pc_q),
        .instr_valid_i     (instr_valid_q),
        .redirect_valid_i  (redirect_valid),
        .redirect_target_i (redirect_target),
        .next_pc_o         (nextPc),
        .misaligned_o      (misaligned)
    );

    assign advance = !stall && (state_q == RUN);
    assign haltNow = advance && (pc_q == HALT_ADDR);

    // Next-state logic. Every advance cycle captures the current word into IR.
    // On the halt edge the PC stays parked at HALT_ADDR and any redirect is
    // dropped; once halted, IR is marked empty on every edge so decode stops
    // seeing instructions, while everything else holds.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        addr_error_d  = addr_error_q;
        fetch_count_d = fetch_count_q;
        if (advance) begin
            instr_d       = instr_readdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
            if (haltNow) begin
                state_d = HALTED;
            end else begin
                pc_d = nextPc;
                if (misaligned) begin
                    addr_error_d = 1'b1;
                end
            end
        end else if (state_q == HALTED) begin
            instr_valid_d = 1'b0;
        end
    end

    // State registers with asynchronous reset to the boot state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_VECTOR;
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
            instr_valid_q <= 1'b0;
            addr_error_q  <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            addr_error_q  <= addr_error_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign instr_address = pc_q;
    assign instr         = instr_q;
    assign instr_pc      = instr_pc_q;
    assign instr_valid   = instr_valid_q;
    assign active        = (state_q == RUN);
    assign addr_error    = addr_error_q;
    assign fetch_count   = fetch_count_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_mips_fetch_unit
// Directed vectors for the fetch unit against a tiny instruction memory.
// ----------------------------------------------------------------------------
module tb_mips_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        active;
    logic        addr_error;
    logic [31:0] fetch_count;

    int total;
    int bad;

    typedef struct {
        logic        stall;
        logic        rv;
        logic [31:0] rt;
        logic [31:0] eAddr;
        logic [31:0] eInstr;
        logic [31:0] ePc;
        logic        eValid;
        logic        eActive;
        logic        eErr;
        logic [31:0] eCnt;
    } vec_t;

    vec_t vecs[$];

    mips_fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_valid     (instr_valid),
        .active          (active),
        .addr_error      (addr_error),
        .fetch_count     (fetch_count)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory returns the address as data, except a "jr r0; nop" pair at
    // 0xBFC00028 / 0xBFC0002C.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        case (a)
            32'hBFC0_0028: return 32'h0000_0008;
            32'hBFC0_002C: return 32'h0000_0000;
            default:       return a;
        endcase
    endfunction

    always_comb instr_readdata = memWord(instr_address);

    function automatic vec_t mkVec(input logic st, input logic rv, input logic [31:0] rt,
                                   input logic [31:0] eAddr, input logic [31:0] eInstr,
                                   input logic [31:0] ePc, input logic eValid,
                                   input logic eActive, input logic eErr,
                                   input logic [31:0] eCnt);
        vec_t v;
        v.stall   = st;
        v.rv      = rv;
        v.rt      = rt;
        v.eAddr   = eAddr;
        v.eInstr  = eInstr;
        v.ePc     = ePc;
        v.eValid  = eValid;
        v.eActive = eActive;
        v.eErr    = eErr;
        v.eCnt    = eCnt;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rt);
        stall           = st;
        redirect_valid  = rv;
        redirect_target = rt;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        check32({tag, ".addr"},   instr_address, v.eAddr);
        check32({tag, ".instr"},  instr, v.eInstr);
        check32({tag, ".pc"},     instr_pc, v.ePc);
        check32({tag, ".valid"},  {31'd0, instr_valid}, {31'd0, v.eValid});
        check32({tag, ".active"}, {31'd0, active}, {31'd0, v.eActive});
        check32({tag, ".err"},    {31'd0, addr_error}, {31'd0, v.eErr});
        check32({tag, ".count"},  fetch_count, v.eCnt);
    endtask

    task automatic runVecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            applyStimulus(vecs[i].stall, vecs[i].rv, vecs[i].rt);
            @(posedge clk);
            #1;
            checkOutput($sformatf("row%0d", i), vecs[i]);
        end
    endtask

    initial begin
        vec_t rstVec;
        total = 0;
        bad   = 0;
        rstVec = mkVec(0, 0, 0, 32'hBFC00000, 0, 0, 0, 1, 0, 0);

        // Rows 0..17: sequential, branch, stall, misaligned, halt
        vecs.push_back(mkVec(0, 0, 0,            32'hBFC00004, 32'hBFC00000, 32'hBFC00000, 1, 1, 0, 1));
        vecs.push_back(mkVec(0, 0, 0,            32'hBFC00008, 32'hBFC00004, 32'hBFC00004, 1, 1, 0, 2));
        vecs.push_back(mkVec(0, 0, 0,            32'hBFC0000C, 32'hBFC00008, 32'hBFC00008, 1, 1, 0, 3));
        vecs.push_back(mkVec(0, 1, 32'hBFC00040, 32'hBFC00040, 32'hBFC0000C, 32'hBFC0000C, 1, 1, 0, 4));
        vecs.push_back(mkVec(0, 0, 0,            32'hBFC00044, 32'hBFC00040, 32'hBFC00040, 1, 1, 0, 5));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mkVec(1, 1, 32'hBFC00080, 32'hBFC00044, 32'hBFC00040, 32'hBFC00040, 1, 1, 0, 5));
        vecs.push_back(mkVec(0, 1, 32'hBFC00080, 32'hBFC00080, 32'hBFC00044, 32'hBFC00044, 1, 1, 0, 6));
        vecs.push_back(mkVec(0, 0, 0,            32'hBFC00084, 32'hBFC00080, 32'hBFC00080, 1, 1, 0, 7));
        vecs.push_back(mkVec(0, 1, 32'hBFC00042, 32'hBFC00040, 32'hBFC00084, 32'hBFC00084, 1, 1, 1, 8));
        vecs.push_back(mkVec(0, 0, 0,            32'hBFC00044, 32'hBFC00040, 32'hBFC00040, 1, 1, 1, 9));
        vecs.push_back(mkVec(0, 1, 32'hBFC00028, 32'hBFC00028, 32'hBFC00044, 32'hBFC00044, 1, 1, 1, 10));
        vecs.push_back(mkVec(0, 0, 0,            32'hBFC0002C, 32'h00000008, 32'hBFC00028, 1, 1, 1, 11));
        vecs.push_back(mkVec(0, 1, 32'h00000000, 32'h00000000, 32'h00000000, 32'hBFC0002C, 1, 1, 1, 12));
        vecs.push_back(mkVec(0, 1, 32'hBFC00100, 32'h00000000, 32'h00000000, 32'h00000000, 1, 0, 1, 13));
        vecs.push_back(mkVec(0, 0, 0,            32'h00000000, 32'h00000000, 32'h00000000, 0, 0, 1, 13));
        // Rows 18..22: after reset, redirect near the top of memory and wrap into halt
        vecs.push_back(mkVec(0, 0, 0,            32'hBFC00008, 32'hBFC00004, 32'hBFC00004, 1, 1, 0, 2));
        vecs.push_back(mkVec(0, 1, 32'hFFFFFFF8, 32'hFFFFFFF8, 32'hBFC00008, 32'hBFC00008, 1, 1, 0, 3));
        vecs.push_back(mkVec(0, 0, 0,            32'hFFFFFFFC, 32'hFFFFFFF8, 32'hFFFFFFF8, 1, 1, 0, 4));
        vecs.push_back(mkVec(0, 0, 0,            32'h00000000, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 1, 0, 5));
        vecs.push_back(mkVec(0, 0, 0,            32'h00000000, 32'h00000000, 32'h00000000, 1, 0, 0, 6));

        rst_n = 1'b0;
        applyStimulus(0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", rstVec);
        rst_n = 1'b1;

        runVecs(0, 17);

        // Halted: nothing moves regardless of stall/redirect activity
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            @(posedge clk);
            #1;
            checkOutput($sformatf("halt%0d", i),
                        mkVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 13));
        end

        // Asynchronous reset between edges, with stall and redirect asserted
        applyStimulus(1, 1, 32'hBFC00100);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRst", rstVec);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0);
        @(posedge clk);
        #1;
        checkOutput("firstFetch",
                    mkVec(0, 0, 0, 32'hBFC00004, 32'hBFC00000, 32'hBFC00000, 1, 1, 0, 1));

        runVecs(18, 22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
